// File: rtl/dmaster_st_packet_arbiter_if.sv
// Avalon-ST bundle for the packet arbiter: NUM_IN packet sources in, one
// channelized stream out. The arbiter takes the slave side.
interface dmaster_st_packet_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int CHAN_W = 8
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_startofpacket;
    logic [NUM_IN-1:0]        in_endofpacket;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CHAN_W-1:0]        out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
    );

    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
    );
endinterface

// File: rtl/dmaster_st_packet_arbiter.sv
// Packet-level round-robin arbiter: locks a source from its first accepted
// beat to its EOP beat and tags each output beat with the source index.
module dmaster_st_packet_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int CHAN_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    dmaster_st_packet_arbiter_if.slave bus,
    output logic                      busy
);
    localparam int PTR_W = $clog2(NUM_IN);

    typedef enum logic {IDLE, LOCKED} state_t;
    typedef logic [PTR_W-1:0] ptr_t;

    state_t            state, state_nxt;
    ptr_t              rr_ptr, rr_nxt, grant, grant_nxt, sel, idx;
    logic              sel_vld, can_load, accept, sel_sop, sel_eop;
    logic [DATA_W-1:0] sel_data;
    logic              vld_p0, sop_p0, eop_p0;
    logic [DATA_W-1:0] data_p0;
    logic [CHAN_W-1:0] chan_p0;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (int'(p) == NUM_IN - 1) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign can_load = !vld_p0 || bus.out_ready;
    assign accept   = can_load && sel_vld;
    assign busy     = (state == LOCKED);

    // Descending scan so the source closest to rr_ptr wins the last write.
    always_comb begin
        sel     = grant;
        sel_vld = 1'b0;
        idx     = '0;
        if (state == LOCKED) begin
            sel_vld = bus.in_valid[grant];
        end else begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                idx = ptr_t'((int'(rr_ptr) + k) % NUM_IN);
                if (bus.in_valid[idx]) begin
                    sel     = idx;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data     = '0;
        sel_sop      = 1'b0;
        sel_eop      = 1'b0;
        bus.in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (ptr_t'(i) == sel) begin
                sel_data        = bus.in_data[i*DATA_W +: DATA_W];
                sel_sop         = bus.in_startofpacket[i];
                sel_eop         = bus.in_endofpacket[i];
                bus.in_ready[i] = reset_n && can_load && (state == LOCKED || sel_vld);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_eop) begin
                        rr_nxt = ptr_inc(sel);
                    end else begin
                        grant_nxt = sel;
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept && sel_eop) begin
                    state_nxt = IDLE;
                    rr_nxt    = ptr_inc(grant);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            grant  <= grant_nxt;
        end
    end

    // Stage p0: one-deep output register, holds while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            chan_p0 <= '0;
            sop_p0  <= 1'b0;
            eop_p0  <= 1'b0;
        end else if (can_load) begin
            vld_p0 <= accept;
            if (accept) begin
                data_p0 <= sel_data;
                chan_p0 <= CHAN_W'(sel);
                sop_p0  <= sel_sop;
                eop_p0  <= sel_eop;
            end
        end
    end

    assign bus.out_valid         = vld_p0;
    assign bus.out_data          = data_p0;
    assign bus.out_channel       = chan_p0;
    assign bus.out_startofpacket = sop_p0;
    assign bus.out_endofpacket   = eop_p0;
endmodule
